// File: rtl/gate_check_pkg.sv
// Shared constants and types for the exhaustive gate truth-table checker.
package gate_check_pkg;

    // State encoding of the sweep sequencer
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SETTLE = ST_SETTLE,
        S_SAMPLE = ST_SAMPLE
    } state_t;

    // Default gate width and its vector count
    localparam int N_IN_DEFAULT = 3;
    localparam int NUM_VEC      = 1 << N_IN_DEFAULT;

    // Reference truth tables for 3-input gates (bit k = output for input k)
    localparam logic [7:0] TT_NAND3 = 8'h7F;
    localparam logic [7:0] TT_AND3  = 8'h80;
    localparam logic [7:0] TT_NOR3  = 8'h01;

    // Number of input vectors for an arbitrary gate width
    function automatic int num_vec(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/gate_truth_table_checker_settle_timer.sv
// Settle-window timer: counts SETTLE cycles and flags the last one.
module settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic tc
);

    localparam int W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [W-1:0] LAST_CNT = W'(SETTLE_CYCLES - 1);

    logic [W-1:0] r_count;

    // Count settle cycles; load restarts the window at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + W'(1);
        end
    end

    // Terminal count is seen during the final settle cycle of the window
    assign tc = enable && (r_count == LAST_CNT);

endmodule

// File: rtl/gate_truth_table_checker.sv
// Exhaustive sequencer: drives every input vector of a gate, waits a settle
// window, samples the gate output and accumulates mismatch results.
module gate_truth_table_checker
    import gate_check_pkg::*;
#(
    parameter int                     N_IN          = 3,
    parameter int                     SETTLE_CYCLES = 2,
    parameter logic [(1<<N_IN)-1:0]   EXPECTED      = TT_NAND3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      dut_out,
    output logic [N_IN-1:0]           dut_in,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [N_IN:0]             fail_count,
    output logic [(1<<N_IN)-1:0]      fail_mask,
    output logic [N_IN-1:0]           first_fail_idx
);

    localparam int N_VEC = num_vec(N_IN);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(N_VEC - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_start_sweep;
    logic                   w_sample;
    logic                   w_last_sample;
    logic                   w_timer_load;
    logic                   w_timer_en;
    logic                   w_tc;
    logic                   w_mismatch;

    logic [N_IN-1:0]        r_dut_in;
    logic                   r_done;
    logic                   r_pass;
    logic [N_IN:0]          r_fail_count;
    logic [N_VEC-1:0]       r_fail_mask;
    logic [N_IN-1:0]        r_first_fail_idx;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_timer_load),
        .enable (w_timer_en),
        .tc     (w_tc)
    );

    // Sampled output disagrees with the expected truth-table bit
    assign w_mismatch = (dut_out != EXPECTED[r_dut_in]);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        w_state_next  = r_state;
        w_start_sweep = 1'b0;
        w_sample      = 1'b0;
        w_last_sample = 1'b0;
        w_timer_load  = 1'b0;
        w_timer_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_sweep = 1'b1;
                    w_timer_load  = 1'b1;
                    w_state_next  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                w_timer_en = 1'b1;
                if (w_tc) begin
                    w_state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                w_sample = 1'b1;
                if (r_dut_in == LAST_VEC) begin
                    w_last_sample = 1'b1;
                    w_state_next  = S_IDLE;
                end else begin
                    w_timer_load  = 1'b1;
                    w_state_next  = S_SETTLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Vector counter and result accumulation; results hold until next start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dut_in         <= '0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_fail_count     <= '0;
            r_fail_mask      <= '0;
            r_first_fail_idx <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_start_sweep) begin
                r_dut_in         <= '0;
                r_pass           <= 1'b0;
                r_fail_count     <= '0;
                r_fail_mask      <= '0;
                r_first_fail_idx <= '0;
            end else if (w_sample) begin
                if (w_mismatch) begin
                    r_fail_mask[r_dut_in] <= 1'b1;
                    r_fail_count          <= r_fail_count + (N_IN+1)'(1);
                    if (r_fail_count == '0) begin
                        r_first_fail_idx <= r_dut_in;
                    end
                end
                if (w_last_sample) begin
                    r_done <= 1'b1;
                    r_pass <= (r_fail_count == '0) && !w_mismatch;
                end else begin
                    r_dut_in <= r_dut_in + N_IN'(1);
                end
            end
        end
    end

    assign dut_in         = r_dut_in;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
    assign pass           = r_pass;
    assign fail_count     = r_fail_count;
    assign fail_mask      = r_fail_mask;
    assign first_fail_idx = r_first_fail_idx;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Self-checking bench: random and directed gate models swept by two checker
// instances (settle window 2 and 1), compared against a truth-table model.
module tb_gate_truth_table_checker;

    localparam logic [7:0] EXP_TT = 8'h7F;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] gate_tt;
    bit         sel_b;

    logic [2:0] a_dut_in, b_dut_in;
    logic       a_dut_out, b_dut_out;
    logic       a_busy, b_busy, a_done, b_done, a_pass, b_pass;
    logic [3:0] a_fail_count, b_fail_count;
    logic [7:0] a_fail_mask, b_fail_mask;
    logic [2:0] a_first, b_first;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Combinational gate models under test
    assign a_dut_out = gate_tt[a_dut_in];
    assign b_dut_out = gate_tt[b_dut_in];

    gate_truth_table_checker #(
        .N_IN(3), .SETTLE_CYCLES(2), .EXPECTED(EXP_TT)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_out(a_dut_out),
        .dut_in(a_dut_in), .busy(a_busy), .done(a_done), .pass(a_pass),
        .fail_count(a_fail_count), .fail_mask(a_fail_mask),
        .first_fail_idx(a_first)
    );

    gate_truth_table_checker #(
        .N_IN(3), .SETTLE_CYCLES(1), .EXPECTED(EXP_TT)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_out(b_dut_out),
        .dut_in(b_dut_in), .busy(b_busy), .done(b_done), .pass(b_pass),
        .fail_count(b_fail_count), .fail_mask(b_fail_mask),
        .first_fail_idx(b_first)
    );

    // Observed signals of the instance currently under check
    wire [2:0] o_in    = sel_b ? b_dut_in     : a_dut_in;
    wire       o_busy  = sel_b ? b_busy       : a_busy;
    wire       o_done  = sel_b ? b_done       : a_done;
    wire       o_pass  = sel_b ? b_pass       : a_pass;
    wire [3:0] o_cnt   = sel_b ? b_fail_count : a_fail_count;
    wire [7:0] o_mask  = sel_b ? b_fail_mask  : a_fail_mask;
    wire [2:0] o_first = sel_b ? b_first      : a_first;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dut_in"}, o_in,    0);
        check({tag, "_busy"},   o_busy,  0);
        check({tag, "_done"},   o_done,  0);
        check({tag, "_pass"},   o_pass,  0);
        check({tag, "_cnt"},    o_cnt,   0);
        check({tag, "_mask"},   o_mask,  0);
        check({tag, "_first"},  o_first, 0);
    endtask

    // One full sweep with expectations derived from the gate truth table
    task automatic run_sweep(input bit use_b, input logic [7:0] tt, input bit jitter);
        int         p;
        int         last_edge;
        logic [7:0] m;
        int         cnt;
        int         first;
        for (int i = 0; i < 40 && (a_busy || b_busy); i++) tick();
        check("idle_before_start", a_busy | b_busy, 0);
        sel_b     = use_b;
        p         = use_b ? 2 : 3;
        last_edge = 8 * p;
        gate_tt   = tt;
        m         = tt ^ EXP_TT;
        cnt       = $countones(m);
        first     = 0;
        for (int k = 7; k >= 0; k--) if (m[k]) first = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e <= last_edge; e++) begin
            if (e < last_edge) begin
                check("busy", o_busy, 1);
                check("done_early", o_done, 0);
                check("dut_in", o_in, e / p);
                if (jitter && e < last_edge - 1) start = 1'($urandom_range(0, 1));
                else start = 1'b0;
                tick();
            end else begin
                check("done", o_done, 1);
                check("busy_end", o_busy, 0);
                check("pass", o_pass, (m == 8'h00) ? 1 : 0);
                check("fail_count", o_cnt, cnt);
                check("fail_mask", o_mask, m);
                check("first_fail", o_first, first);
            end
        end
        tick();
        check("done_clear", o_done, 0);
        check("hold_in", o_in, 7);
        check("hold_cnt", o_cnt, cnt);
        check("hold_mask", o_mask, m);
        $display("sweep inst=%0d tt=%02h -> mask=%02h cnt=%0d pass=%0d",
                 use_b, tt, o_mask, o_cnt, o_pass);
    endtask

    initial begin
        int done_edges[$];
        rst_n   = 1'b0;
        start   = 1'b0;
        gate_tt = 8'h7F;
        sel_b   = 1'b0;
        repeat (3) tick();
        check_all_zero("reset_a");
        sel_b = 1'b1;
        check_all_zero("reset_b");
        sel_b = 1'b0;
        rst_n = 1'b1;
        tick();

        // Directed: correct NAND3, stuck-at-1, AND3 model, NOR3 model
        run_sweep(1'b0, 8'h7F, 1'b0);
        run_sweep(1'b0, 8'hFF, 1'b0);
        run_sweep(1'b0, 8'h80, 1'b0);
        run_sweep(1'b0, 8'h01, 1'b1);

        // Reset mid-sweep at edge 10, restart at edge 15
        sel_b   = 1'b0;
        gate_tt = 8'h7F;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 9; e++) tick();
        rst_n = 1'b0;
        tick();
        check_all_zero("midreset");
        rst_n = 1'b1;
        for (int e = 11; e <= 14; e++) begin
            tick();
            check("midreset_no_done", o_done, 0);
            check("midreset_idle", o_busy, 0);
        end
        run_sweep(1'b0, 8'h7F, 1'b0);

        // Start held high: back-to-back sweeps
        sel_b   = 1'b0;
        gate_tt = 8'h7F;
        start   = 1'b1;
        for (int e = 0; e <= 52; e++) begin
            tick();
            if (a_done) done_edges.push_back(e);
        end
        start = 1'b0;
        check("held_done_count", done_edges.size(), 2);
        if (done_edges.size() >= 2) begin
            check("held_done_0", done_edges[0], 24);
            check("held_done_1", done_edges[1], 49);
        end
        $display("held start: %0d done pulses", done_edges.size());
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Settle window of one cycle
        run_sweep(1'b1, 8'h7F, 1'b0);

        // Random gate models on both instances, with start noise mid-sweep
        for (int r = 0; r < 8; r++) begin
            run_sweep(r[0], 8'($urandom), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gate_truth_table_checker.md
# gate_truth_table_checker

Self-checking sequencer for a combinational N-input gate under test, e.g. the 3-input NAND. On `start` it walks `dut_in` through all 2^N_IN input vectors in ascending binary order. It holds each vector for a programmable settle window, samples `dut_out` and compares it against a parameterised expected truth table. It sits between the lab top level (buttons/LEDs) and the gate instance, and replaces hand-timed stimulus with a clocked, repeatable exhaustive check.

## Interface
Parameters:
- `N_IN`, 3: number of gate inputs (1..4).
- `SETTLE_CYCLES`, 2: cycles each vector is driven before sampling; must be ≥1.
- `EXPECTED`, 8'h7F: truth table, bit k = expected `dut_out` for `dut_in == k`; width 2^N_IN. The default is 3-input NAND.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  level; accepted only in IDLE.
- `dut_out`  in  1  output of gate under test.
- `dut_in`  out  N_IN  vector driven to gate.
- `busy`  out  1  high while a sweep runs.
- `done`  out  1  one-cycle pulse at end of sweep.
- `pass`  out  1  1 iff last completed sweep had zero mismatches.
- `fail_count`  out  N_IN+1  mismatches in last sweep (0..2^N_IN).
- `fail_mask`  out  2^N_IN  bit k set if vector k mismatched.
- `first_fail_idx`  out  N_IN  lowest mismatching vector; 0 when `fail_count == 0`.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE.
- IDLE -> SETTLE when `start` is high at the edge. At that edge:
  - `dut_in` <= 0, settle counter <= 0, `busy` <= 1.
  - `pass`, `fail_count`, `fail_mask` and `first_fail_idx` are cleared.
- SETTLE: counter increments each cycle. On the SETTLE_CYCLES-th SETTLE cycle -> SAMPLE.
- SAMPLE (exactly one cycle): at its closing edge, compare `dut_out` with `EXPECTED[dut_in]`.
  - On mismatch: set `fail_mask[dut_in]` and increment `fail_count`. If this is the first mismatch, load `first_fail_idx` <= `dut_in`.
  - If `dut_in` is not the last vector (2^N_IN−1): `dut_in` <= `dut_in`+1, counter <= 0, -> SETTLE.
  - If `dut_in` is the last vector: -> IDLE, `busy` <= 0, `done` <= 1. `pass` <= 1 iff no mismatch occurred, including this sample.
- `done` self-clears on the next edge.
- Results hold until the next accepted `start`.
- `dut_in` keeps its final value (2^N_IN−1) in IDLE.
- `fail_count` saturation is not needed; the width covers all-fail.

## Timing
- Reset (`rst_n` low at an edge): state IDLE. All outputs 0: `dut_in`, `busy`, `done`, `pass`, `fail_count`, `fail_mask`, `first_fail_idx`.
- Reset mid-sweep aborts immediately. No `done` is produced and results read 0.
- Let edge 0 be the `start` acceptance edge and P = SETTLE_CYCLES+1.
  - Vector k is driven from edge k·P and sampled at edge (k+1)·P.
  - `done` is registered at edge 2^N_IN·P and is high for one cycle.
  - Defaults give P = 3: `done` at edge 24.
- `busy` is high from edge 0 up to edge 2^N_IN·P, and falls at the same edge `done` rises.
- `start` while busy is ignored and has no effect on the sweep.
- `start` held high continuously gives back-to-back sweeps. The next start is accepted at edge 2^N_IN·P+1, so there is one IDLE cycle between sweeps.
- `dut_out` is treated as synchronous to `clk`. There is no synchroniser: the gate is combinational from `dut_in`.

## Structure
- Shared package `gate_check_pkg`:
  - state encoding localparams `ST_IDLE`, `ST_SETTLE`, `ST_SAMPLE`.
  - `NUM_VEC = 1 << N_IN`.
  - default truth-table constants `TT_NAND3` (8'h7F), `TT_AND3` (8'h80), `TT_NOR3` (8'h01).
- One sub-module: `settle_timer`.
  - Ports: load, enable, terminal-count pulse.
  - Width: $clog2(SETTLE_CYCLES+1).
- The FSM, vector counter and result registers stay in the top.

## Test plan
- Correct NAND3 model, defaults, `start` pulsed one cycle:
  - `dut_in` is 000 during edges 0–2, 001 during 3–5, …, 111 during 21–23.
  - `done` at edge 24; `pass`=1, `fail_count`=0, `fail_mask`=8'h00.
- Stuck-at-1 DUT (`dut_out`=1): `done` at 24; `pass`=0, `fail_count`=1, `fail_mask`=8'h80, `first_fail_idx`=7.
- AND3 model checked against default EXPECTED: `fail_count`=8 (4'b1000), `fail_mask`=8'hFF, `first_fail_idx`=0, `pass`=0.
- Reset during a sweep:
  - `rst_n` low at edge 10: all outputs 0 next cycle and no `done` ever.
  - New `start` at edge 15 gives `done` at edge 39 with correct results.
- `start` held high throughout: `done` pulses at edges 24 and 49. Extra `start` pulses mid-sweep change nothing.
- `SETTLE_CYCLES`=1, NAND3 model: vectors change every 2 cycles, `done` at edge 16, `pass`=1.
